svnet_ram_reader: RTL

- Initiator-side read client for svnet_ram.
- Accepts a transfer command (start address, length) and issues one RAM read per cycle.
- Absorbs the fixed RAM read-to-valid latency with a credit-limited buffer and streams words out on a valid/ready interface with a last marker.
- Sits between svnet_ram instances and downstream layer/datapath consumers.

---
 rtl/svnet_ram_reader_pkg.sv | 19 +
 rtl/svnet_stream_fifo.sv | 67 ++++++
 rtl/svnet_ram_reader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/svnet_ram_reader_pkg.sv
// svnet_ram_reader_pkg: shared types and constants for the svnet_ram read client.
//   - rd_state_e   : reader FSM states
//   - SVNET_RAM_R2V_DELAY : default RAM read-to-valid latency
//   - credit_w()   : width of a counter that must hold 0..buf_depth
package svnet_ram_reader_pkg;

    localparam int SVNET_RAM_R2V_DELAY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    function automatic int credit_w(input int buf_depth);
        return $clog2(buf_depth + 1);
    endfunction

endpackage

// File: rtl/svnet_stream_fifo.sv
// svnet_stream_fifo: small synchronous FIFO feeding a valid/ready stream.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             drop all entries (pointers and count to 0)
//   push, push_data   write one entry (caller guarantees space)
//   pop               consume head when valid
//   valid, head       head entry, forced to 0 while empty
//   count             number of stored entries
module svnet_stream_fifo #(
    parameter int DW    = 2,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;
    logic          do_pop;

    assign do_pop = pop && valid;
    assign valid  = (cnt != '0);
    // Head comes straight from storage flops; gating to 0 keeps stale
    // words (and stale last markers) off the stream while empty.
    assign head   = valid ? mem[rptr] : '0;
    assign count  = cnt;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push)   wptr <= ptr_inc(wptr);
            if (do_pop) rptr <= ptr_inc(rptr);
            case ({push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !do_pop && cnt == CW'(DEPTH)));

endmodule

// File: rtl/svnet_ram_reader.sv
// svnet_ram_reader: read client for svnet_ram. Takes (address, length),
// issues one RAM read per cycle under a credit limit, buffers the returned
// words and streams them out on valid/ready with a last marker.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   abort                           (SVNET_RAM_READER_ABORT_EN only) cancel transfer
//   start, start_address, start_length   command, sampled in IDLE
//   busy, done                      transfer in progress / completion pulse
//   ram_read, ram_read_address      RAM read request
//   ram_read_data_valid, ram_read_data   RAM return
//   out_valid, out_ready, out_data, out_last   output stream
// Optional feature macro: SVNET_RAM_READER_ABORT_EN adds the abort input.
module svnet_ram_reader
    import svnet_ram_reader_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int DEPTH     = 1,
    parameter int LATENCY   = SVNET_RAM_R2V_DELAY,
    parameter int BUF_DEPTH = LATENCY + 1,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SVNET_RAM_READER_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [AW-1:0]    start_address,
    input  logic [LW-1:0]    start_length,
    output logic             busy,
    output logic             done,
    output logic             ram_read,
    output logic [AW-1:0]    ram_read_address,
    input  logic             ram_read_data_valid,
    input  logic [WIDTH-1:0] ram_read_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam int CW = credit_w(BUF_DEPTH);

    if (BUF_DEPTH < LATENCY + 1) begin : g_bad_buf_depth
        $error("svnet_ram_reader: BUF_DEPTH must be >= LATENCY+1");
    end

    rd_state_e     state, nstate;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] issue_rem, ret_rem;
    logic [CW-1:0] in_flight, fifo_cnt;
    logic          done_q, done_set;
    logic          pop, ret_ok, push, discard, abort_now, credit_ok, can_issue;

`ifdef SVNET_RAM_READER_ABORT_EN
    logic abort_q;
    assign abort_now = abort && (state != IDLE);
    assign discard   = abort_now || abort_q;
`else
    assign abort_now = 1'b0;
    assign discard   = 1'b0;
`endif

    assign pop    = out_valid && out_ready;
    // Returns with nothing outstanding are stray and ignored.
    assign ret_ok = ram_read_data_valid && (in_flight != '0);
    assign push   = ret_ok && !discard;

    // A slot popped this cycle is free for a read issued this cycle; this is
    // what lets the pipe sustain one word per cycle with BUF_DEPTH=LATENCY+1.
    assign credit_ok = (int'(fifo_cnt) + int'(in_flight) - int'(pop)) < BUF_DEPTH;
    assign can_issue = (state == ISSUE) && (issue_rem != '0) && credit_ok && !abort_now;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state logic
    always_comb begin
        nstate   = state;
        done_set = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_length == '0) done_set = 1'b1;
                    else                    nstate   = ISSUE;
                end
            end
            ISSUE: begin
                if (abort_now || (can_issue && issue_rem == LW'(1))) nstate = DRAIN;
            end
            DRAIN: begin
`ifdef SVNET_RAM_READER_ABORT_EN
                if (abort_q) begin
                    if (in_flight == '0) nstate = IDLE;
                end else
`endif
                if (pop && out_last) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
        if (state != IDLE && nstate == IDLE) done_set = 1'b1;
    end

    // Outputs
    always_comb begin
        busy             = (state != IDLE);
        ram_read         = can_issue;
        ram_read_address = addr_q;
        done             = done_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            issue_rem <= '0;
            ret_rem   <= '0;
            in_flight <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= done_set;
            if (state == IDLE && start) begin
                addr_q    <= start_address;
                issue_rem <= start_length;
                ret_rem   <= start_length;
            end else begin
                if (can_issue) begin
                    addr_q    <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
                    issue_rem <= issue_rem - LW'(1);
                end
                if (push) ret_rem <= ret_rem - LW'(1);
            end
            case ({can_issue, ret_ok})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

`ifdef SVNET_RAM_READER_ABORT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)              abort_q <= 1'b0;
        else if (nstate == IDLE) abort_q <= 1'b0;
        else if (abort_now)      abort_q <= 1'b1;
    end
`endif

    logic [WIDTH:0] fifo_head;

    svnet_stream_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort_now),
        .push      (push),
        .push_data ({(ret_rem == LW'(1)), ram_read_data}),
        .pop       (out_ready),
        .valid     (out_valid),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    assign out_last = fifo_head[WIDTH];
    assign out_data = fifo_head[WIDTH-1:0];

    a_no_stray_return: assert property (@(posedge clk) disable iff (!rst_n)
        !(ram_read_data_valid && in_flight == '0));

endmodule
